// File: rtl/quiz_buzzer_ctrl.sv
// ============================================================================
// Module   : quiz_buzzer_ctrl
// Brief    : Quiz-show buzzer arbiter with countdown bar, false-start lockout
//            and saturating per-player scores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module quiz_buzzer_ctrl #(
    parameter int N_PLAYERS = 4,
    parameter int SCORE_W   = 5,
    parameter int TICK_DIV  = 50_000_000,
    parameter int COUNTDOWN = 8
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic [N_PLAYERS-1:0]           player_btn_n,
    input  logic                           start_btn_n,
    input  logic                           reset_btn_n,
    input  logic                           add_btn_n,
    input  logic                           sub_btn_n,
    input  logic                           clear_btn_n,
    output logic [1:0]                     state,
    output logic [$clog2(N_PLAYERS)-1:0]   winner,
    output logic                           winner_valid,
    output logic [3:0]                     countdown,
    output logic [COUNTDOWN-1:0]           leds,
    output logic [N_PLAYERS*SCORE_W-1:0]   scores,
    output logic [N_PLAYERS-1:0]           lockout
);

    localparam int                  c_WIN_W      = $clog2(N_PLAYERS);
    localparam int                  c_TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int                  c_BTN_W      = N_PLAYERS + 5;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0]  c_SCORE_MAX  = '1;
    localparam logic [3:0]          c_COUNT_INIT = 4'(COUNTDOWN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_ANSWER  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    // Button front end: 2-flop synchroniser, then a registered falling-edge pulse
    logic [c_BTN_W-1:0] w_btn_raw;
    logic [c_BTN_W-1:0] r_sync1;
    logic [c_BTN_W-1:0] r_sync2;
    logic [c_BTN_W-1:0] r_prev;
    logic [c_BTN_W-1:0] r_evt;

    assign w_btn_raw = {clear_btn_n, sub_btn_n, add_btn_n, reset_btn_n, start_btn_n, player_btn_n};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
            r_evt   <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_evt   <= r_prev & ~r_sync2;
        end
    end

    logic [N_PLAYERS-1:0] w_evt_player;
    logic                 w_evt_start;
    logic                 w_evt_reset;
    logic                 w_evt_add;
    logic                 w_evt_sub;
    logic                 w_evt_clear;

    assign w_evt_player = r_evt[N_PLAYERS-1:0];
    assign w_evt_start  = r_evt[N_PLAYERS];
    assign w_evt_reset  = r_evt[N_PLAYERS+1];
    assign w_evt_add    = r_evt[N_PLAYERS+2];
    assign w_evt_sub    = r_evt[N_PLAYERS+3];
    assign w_evt_clear  = r_evt[N_PLAYERS+4];

    state_t                       r_state,     w_state_nxt;
    logic [c_WIN_W-1:0]           r_winner,    w_winner_nxt;
    logic [3:0]                   r_countdown, w_countdown_nxt;
    logic [c_TICK_W-1:0]          r_tick,      w_tick_nxt;
    logic [N_PLAYERS*SCORE_W-1:0] r_scores,    w_scores_nxt;
    logic [N_PLAYERS-1:0]         r_lockout,   w_lockout_nxt;

    logic [N_PLAYERS-1:0] w_valid;
    logic [c_WIN_W-1:0]   w_first;
    logic [SCORE_W-1:0]   w_cur_score;

    assign w_valid     = w_evt_player & ~r_lockout;
    assign w_cur_score = r_scores[int'(r_winner)*SCORE_W +: SCORE_W];

    // Lowest unlocked index wins a simultaneous press
    always_comb begin
        w_first = '0;
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (w_valid[k]) begin
                w_first = c_WIN_W'(k);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_winner    <= '0;
            r_countdown <= '0;
            r_tick      <= '0;
            r_scores    <= '0;
            r_lockout   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_winner    <= w_winner_nxt;
            r_countdown <= w_countdown_nxt;
            r_tick      <= w_tick_nxt;
            r_scores    <= w_scores_nxt;
            r_lockout   <= w_lockout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_winner_nxt    = r_winner;
        w_countdown_nxt = r_countdown;
        w_tick_nxt      = r_tick;
        w_scores_nxt    = r_scores;
        w_lockout_nxt   = r_lockout;
        case (r_state)
            S_IDLE: begin
                w_lockout_nxt = r_lockout | w_evt_player;
                if (w_evt_clear) begin
                    w_scores_nxt  = '0;
                    w_lockout_nxt = '0;
                end
                if (w_evt_start) begin
                    w_state_nxt     = S_ARMED;
                    w_countdown_nxt = c_COUNT_INIT;
                    w_tick_nxt      = '0;
                end
            end
            S_ARMED: begin
                // A valid buzz beats a simultaneous final tick
                if (|w_valid) begin
                    w_state_nxt  = S_ANSWER;
                    w_winner_nxt = w_first;
                end else if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt      = '0;
                    w_countdown_nxt = r_countdown - 4'd1;
                    if (r_countdown == 4'd1) begin
                        w_state_nxt = S_TIMEOUT;
                    end
                end else begin
                    w_tick_nxt = r_tick + c_TICK_W'(1);
                end
            end
            S_ANSWER: begin
                if (w_evt_add ^ w_evt_sub) begin
                    w_state_nxt   = S_IDLE;
                    w_lockout_nxt = '0;
                    if (w_evt_add && (w_cur_score != c_SCORE_MAX)) begin
                        w_scores_nxt[int'(r_winner)*SCORE_W +: SCORE_W] = w_cur_score + SCORE_W'(1);
                    end else if (w_evt_sub && (w_cur_score != '0)) begin
                        w_scores_nxt[int'(r_winner)*SCORE_W +: SCORE_W] = w_cur_score - SCORE_W'(1);
                    end
                end
            end
            S_TIMEOUT: begin
                if (w_evt_reset || w_evt_start) begin
                    w_state_nxt   = S_IDLE;
                    w_lockout_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign state        = r_state;
    assign winner       = r_winner;
    assign winner_valid = (r_state == S_ANSWER);
    assign countdown    = r_countdown;
    assign scores       = r_scores;
    assign lockout      = r_lockout;

    generate
        for (genvar i = 0; i < COUNTDOWN; i++) begin : g_leds
            assign leds[i] = (r_countdown > 4'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_quiz_buzzer_ctrl.sv
// ============================================================================
// Module   : tb_quiz_buzzer_ctrl
// Brief    : Self-checking bench for quiz_buzzer_ctrl (4 players, 3-bit scores).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_quiz_buzzer_ctrl;

    localparam int N_PLAYERS = 4;
    localparam int SCORE_W   = 3;
    localparam int TICK_DIV  = 10;
    localparam int COUNTDOWN = 8;

    localparam logic [8:0] c_NONE  = 9'h000;
    localparam logic [8:0] c_P0    = 9'h001;
    localparam logic [8:0] c_P1    = 9'h002;
    localparam logic [8:0] c_P2    = 9'h004;
    localparam logic [8:0] c_P3    = 9'h008;
    localparam logic [8:0] c_START = 9'h010;
    localparam logic [8:0] c_RSTB  = 9'h020;
    localparam logic [8:0] c_ADD   = 9'h040;
    localparam logic [8:0] c_SUB   = 9'h080;
    localparam logic [8:0] c_CLR   = 9'h100;

    logic        sys_clk;
    logic        rst;
    logic [3:0]  player_btn_n;
    logic        start_btn_n;
    logic        reset_btn_n;
    logic        add_btn_n;
    logic        sub_btn_n;
    logic        clear_btn_n;
    logic [1:0]  state;
    logic [1:0]  winner;
    logic        winner_valid;
    logic [3:0]  countdown;
    logic [7:0]  leds;
    logic [11:0] scores;
    logic [3:0]  lockout;

    quiz_buzzer_ctrl #(
        .N_PLAYERS (N_PLAYERS),
        .SCORE_W   (SCORE_W),
        .TICK_DIV  (TICK_DIV),
        .COUNTDOWN (COUNTDOWN)
    ) u_dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .player_btn_n (player_btn_n),
        .start_btn_n  (start_btn_n),
        .reset_btn_n  (reset_btn_n),
        .add_btn_n    (add_btn_n),
        .sub_btn_n    (sub_btn_n),
        .clear_btn_n  (clear_btn_n),
        .state        (state),
        .winner       (winner),
        .winner_valid (winner_valid),
        .countdown    (countdown),
        .leds         (leds),
        .scores       (scores),
        .lockout      (lockout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  win;
        logic        wv;
        logic [3:0]  cd;
        logic [7:0]  leds;
        logic [11:0] sc;
        logic [3:0]  lk;
    } obs_t;

    typedef struct {
        logic [8:0] btn;
        obs_t       exp;
        string      name;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] leds_of(input logic [3:0] cd);
        logic [8:0] t;
        t = (9'd1 << cd) - 9'd1;
        return (cd >= 4'd8) ? 8'hFF : t[7:0];
    endfunction

    function automatic obs_t mk(input int st, input int w, input int cd, input int sc, input int lk);
        obs_t o;
        o.st   = 2'(st);
        o.win  = 2'(w);
        o.wv   = (st == 2);
        o.cd   = 4'(cd);
        o.leds = leds_of(4'(cd));
        o.sc   = 12'(sc);
        o.lk   = 4'(lk);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st   = state;
        o.win  = winner;
        o.wv   = winner_valid;
        o.cd   = countdown;
        o.leds = leds;
        o.sc   = scores;
        o.lk   = lockout;
        return o;
    endfunction

    task automatic drive(input logic [8:0] m);
        player_btn_n = ~m[3:0];
        start_btn_n  = ~m[4];
        reset_btn_n  = ~m[5];
        add_btn_n    = ~m[6];
        sub_btn_n    = ~m[7];
        clear_btn_n  = ~m[8];
    endtask

    // Called on a falling edge; returns on the falling edge after the 4th rising edge
    task automatic do_press(input logic [8:0] m);
        drive(m);
        repeat (2) @(negedge sys_clk);
        drive(c_NONE);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic check(input string name);
        obs_t a;
        obs_t e;
        a = sample();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: actual st=%0d win=%0d wv=%0b cd=%0d leds=%h sc=%h lk=%b, required st=%0d win=%0d wv=%0b cd=%0d leds=%h sc=%h lk=%b",
                         name, a.st, a.win, a.wv, a.cd, a.leds, a.sc, a.lk,
                         e.st, e.win, e.wv, e.cd, e.leds, e.sc, e.lk);
            end
        end
    endtask

    task automatic step(input logic [8:0] m, input string name, input obs_t e);
        exp_q.push_back(e);
        do_press(m);
        check(name);
    endtask

    task automatic add_vec(input logic [8:0] m, input string name, input obs_t e);
        vec_t v;
        v.btn  = m;
        v.exp  = e;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int p0;
        int sc;

        // Player k's score sits at bits [3k+2:3k]
        add_vec(c_START,       "r1_start",       mk(1, 0, 8, 12'h000, 4'b0000));
        add_vec(c_P2 | c_P3,   "r1_p2p3_tie",    mk(2, 2, 8, 12'h000, 4'b0000));
        add_vec(c_ADD,         "r1_add_p2",      mk(0, 2, 8, 12'h040, 4'b0000));
        add_vec(c_P1,          "false_start_p1", mk(0, 2, 8, 12'h040, 4'b0010));
        add_vec(c_START,       "r2_start",       mk(1, 2, 8, 12'h040, 4'b0010));
        add_vec(c_P1,          "r2_p1_locked",   mk(1, 2, 8, 12'h040, 4'b0010));
        add_vec(c_P0,          "r2_p0_wins",     mk(2, 0, 8, 12'h040, 4'b0010));
        add_vec(c_ADD,         "r2_add_p0",      mk(0, 0, 8, 12'h041, 4'b0000));
        for (int rr = 2; rr <= 8; rr++) begin
            p0 = (rr > 7) ? 7 : rr;
            sc = 12'h040 | p0;
            add_vec(c_START, $sformatf("sat_start_%0d", rr), mk(1, 0, 8, 12'h040 | (rr - 1), 0));
            add_vec(c_P0,    $sformatf("sat_p0_%0d", rr),    mk(2, 0, 8, 12'h040 | (rr - 1), 0));
            add_vec(c_ADD,   $sformatf("sat_add_%0d", rr),   mk(0, 0, 8, sc, 0));
        end
        add_vec(c_START,       "r3_start",          mk(1, 0, 8, 12'h047, 4'b0000));
        add_vec(c_P1,          "r3_p1",             mk(2, 1, 8, 12'h047, 4'b0000));
        add_vec(c_SUB,         "r3_sub_floor",      mk(0, 1, 8, 12'h047, 4'b0000));
        add_vec(c_START,       "r4_start",          mk(1, 1, 8, 12'h047, 4'b0000));
        add_vec(c_START,       "r4_start_ignored",  mk(1, 1, 8, 12'h047, 4'b0000));
        add_vec(c_P3,          "r4_p3",             mk(2, 3, 8, 12'h047, 4'b0000));
        add_vec(c_ADD | c_SUB, "r4_add_sub_same",   mk(2, 3, 8, 12'h047, 4'b0000));
        add_vec(c_ADD,         "r4_add_p3",         mk(0, 3, 8, 12'h247, 4'b0000));

        rst = 1'b1;
        drive(c_NONE);
        repeat (3) @(negedge sys_clk);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        check("reset_state");
        rst = 1'b0;
        @(negedge sys_clk);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        check("after_reset_release");

        foreach (vecs[i]) begin
            step(vecs[i].btn, vecs[i].name, vecs[i].exp);
        end

        // Full countdown with no buzz; bar drains one LED per tick
        step(c_START, "to_start", mk(1, 3, 8, 12'h247, 0));
        for (int c = 7; c >= 1; c--) begin
            exp_q.push_back(mk(1, 3, c, 12'h247, 0));
            repeat (10) @(negedge sys_clk);
            check($sformatf("to_cd_%0d", c));
        end
        exp_q.push_back(mk(3, 3, 0, 12'h247, 0));
        repeat (10) @(negedge sys_clk);
        check("to_timeout");
        step(c_ADD,  "to_add_ignored", mk(3, 3, 0, 12'h247, 0));
        step(c_RSTB, "to_reset_btn",   mk(0, 3, 0, 12'h247, 0));

        // Second timeout leaves via start, clearing a false-start lock
        step(c_P1,    "to2_false_p1", mk(0, 3, 0, 12'h247, 4'b0010));
        step(c_START, "to2_start",    mk(1, 3, 8, 12'h247, 4'b0010));
        exp_q.push_back(mk(3, 3, 0, 12'h247, 4'b0010));
        repeat (80) @(negedge sys_clk);
        check("to2_timeout");
        step(c_START, "to2_start_exit", mk(0, 3, 0, 12'h247, 0));

        // Buzz lands on the very cycle the countdown would reach zero
        step(c_START, "edge_start", mk(1, 3, 8, 12'h247, 0));
        repeat (76) @(negedge sys_clk);
        step(c_P0,    "edge_buzz_wins", mk(2, 0, 1, 12'h247, 0));
        step(c_ADD,   "edge_add_sat",   mk(0, 0, 1, 12'h247, 0));
        step(c_CLR,   "clear_scores",   mk(0, 0, 1, 12'h000, 0));
        step(c_ADD,   "idle_add_ign",   mk(0, 0, 1, 12'h000, 0));

        // Abort an armed round with the reset pin
        step(c_START, "abort_r_start", mk(1, 0, 8, 12'h000, 0));
        step(c_P2,    "abort_r_p2",    mk(2, 2, 8, 12'h000, 0));
        step(c_ADD,   "abort_r_add",   mk(0, 2, 8, 12'h040, 0));
        step(c_START, "abort_start",   mk(1, 2, 8, 12'h040, 0));
        repeat (3) @(negedge sys_clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        check("rst_mid_armed");
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        check("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quiz_buzzer_ctrl.md
QUIZ_BUZZER_CTRL -- requirements
Module: quiz_buzzer_ctrl

Interface
REQ-001 SHALL provide parameter N_PLAYERS, default 4, number of player buttons (2..8).
REQ-002 SHALL provide parameter SCORE_W, default 5, bits per player score.
REQ-003 SHALL provide parameter TICK_DIV, default 50_000_000, sys_clk cycles per countdown tick.
REQ-004 SHALL provide parameter COUNTDOWN, default 8, ticks per round (1..15).
REQ-005 SHALL have port sys_clk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port player_btn_n  input  N_PLAYERS  player buttons, active-low, asynchronous.
REQ-008 SHALL have ports start_btn_n, reset_btn_n, add_btn_n, sub_btn_n, clear_btn_n  input  1 each  host buttons, active-low, asynchronous.
REQ-009 SHALL have port state  output  2  IDLE=0, ARMED=1, ANSWER=2, TIMEOUT=3.
REQ-010 SHALL have port winner  output  clog2(N_PLAYERS)  index of answering player.
REQ-011 SHALL have port winner_valid  output  1  high only in ANSWER.
REQ-012 SHALL have port countdown  output  4  remaining ticks.
REQ-013 SHALL have port leds  output  COUNTDOWN  bar display, leds[i]=1 iff i < countdown.
REQ-014 SHALL have port scores  output  N_PLAYERS*SCORE_W  packed scores, player k at [k*SCORE_W +: SCORE_W].
REQ-015 SHALL have port lockout  output  N_PLAYERS  per-player false-start lock.

Function
REQ-016 SHALL pass every button through a 2-flop synchroniser, then a registered falling-edge detector; one press = one single-cycle event, held buttons produce no further events.
REQ-017 SHALL act on an event on the clock edge after the event cycle (pin-to-state latency 4 cycles).
REQ-018 IDLE: start event -> ARMED, countdown<=COUNTDOWN, tick counter<=0.
REQ-019 IDLE: player k event -> lockout[k]<=1 (false start); state unchanged.
REQ-020 IDLE: clear event -> all scores<=0, lockout<=0.
REQ-021 ARMED: tick counter counts 0..TICK_DIV-1; at TICK_DIV-1 wraps to 0 and countdown decrements.
REQ-022 ARMED: event from player with lockout=0 -> ANSWER, winner<=that index; simultaneous events -> lowest unlocked index wins; locked players' events ignored.
REQ-023 ARMED: countdown decrement to 0 with no valid player event -> TIMEOUT; valid player event in the same cycle takes priority (ANSWER, countdown unchanged).
REQ-024 ANSWER: add event -> scores[winner]+1, saturating at 2^SCORE_W-1; sub event -> scores[winner]-1, saturating at 0; then IDLE, lockout<=0.
REQ-025 ANSWER: add and sub events in the same cycle -> both ignored, stay ANSWER.
REQ-026 ANSWER/TIMEOUT: countdown frozen; leds reflect frozen value.
REQ-027 TIMEOUT: reset or start event -> IDLE, lockout<=0; scores unchanged.
REQ-028 Start events outside IDLE/TIMEOUT and add/sub events outside ANSWER SHALL be ignored.
REQ-029 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-030 rst high SHALL immediately force state=IDLE, winner=0, winner_valid=0, countdown=0, leds=0, scores=0, lockout=0, tick counter=0, synchronisers/edge registers=1 (released).
REQ-031 rst asserted mid-round SHALL abort the round; no score change from that round survives.

Verification (N_PLAYERS=4, SCORE_W=3, TICK_DIV=10, COUNTDOWN=8)
REQ-032 start press, no players -> ARMED, countdown 8..0 one step per 10 cycles, leds 8'hFF->8'h7F->...->0, TIMEOUT after 80 cycles.
REQ-033 start, players 2 and 3 pressed same cycle -> ANSWER, winner=2; add -> scores[2]=1, IDLE.
REQ-034 player 1 pressed in IDLE -> lockout=4'b0010; start, press 1 then 0 -> winner=0; add -> lockout=0.
REQ-035 player 0 add 8 rounds -> score saturates at 7; sub on score 0 stays 0; add+sub same cycle -> no change, stays ANSWER.
REQ-036 player press on cycle countdown hits 0 -> ANSWER not TIMEOUT; rst mid-ARMED -> all outputs zero immediately.
